// File: rtl/mul_div_unit.sv
// Iterative 16-cycle unsigned multiply / restoring divide unit fed by the register file read ports.
// Define SIGNED_OPS_EN to enable signed MUL (op=10) and signed DIV (op=11); otherwise those ops are reserved.
module mul_div_unit #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [1:0]    op,
   input  logic [DW-1:0] R,
   input  logic [DW-1:0] S,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] Y_hi,
   output logic [DW-1:0] Y_lo,
   output logic          div_by_zero
);

   localparam int CW = $clog2(DW);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state, next_state;
   logic [DW-1:0]   opa, opb;
   logic [2*DW-1:0] acc, step;
   logic [CW-1:0]   count;
   logic            is_div;
   logic            op_valid, div_zero, last_iter;
   logic [DW-1:0]   a_mag, b_mag;
   logic [DW:0]     mul_sum, rem_sh, trial;
   logic [DW-1:0]   res_hi, res_lo;
`ifdef SIGNED_OPS_EN
   logic            neg_q, neg_r;
`endif

   // Signed ops run on magnitudes through the unsigned datapath; signs are restored at load.
   always_comb begin
      op_valid = 1'b1;
      a_mag    = R;
      b_mag    = S;
`ifdef SIGNED_OPS_EN
      if (op[1] && R[DW-1]) a_mag = -R;
      if (op[1] && S[DW-1]) b_mag = -S;
`else
      op_valid = !op[1];
`endif
      div_zero  = op[0] && (S == '0);
      last_iter = (count == CW'(DW - 1));
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (start) next_state = (!op_valid || div_zero) ? DONE : CALC;
         CALC: if (last_iter) next_state = DONE;
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
   always_comb begin
      mul_sum = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, opa} : '0);
      rem_sh  = acc[2*DW-1:DW-1];
      trial   = rem_sh - {1'b0, opb};
      if (is_div) begin
         if (trial[DW]) step = {rem_sh[DW-1:0], acc[DW-2:0], 1'b0};
         else           step = {trial[DW-1:0], acc[DW-2:0], 1'b1};
      end else begin
         step = {mul_sum, acc[DW-1:1]};
      end
   end

   always_comb begin
      res_hi = step[2*DW-1:DW];
      res_lo = step[DW-1:0];
`ifdef SIGNED_OPS_EN
      if (is_div) begin
         if (neg_r) res_hi = -step[2*DW-1:DW];
         if (neg_q) res_lo = -step[DW-1:0];
      end else if (neg_q) begin
         {res_hi, res_lo} = -step;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         opa         <= '0;
         opb         <= '0;
         acc         <= '0;
         count       <= '0;
         is_div      <= 1'b0;
         Y_hi        <= '0;
         Y_lo        <= '0;
         div_by_zero <= 1'b0;
`ifdef SIGNED_OPS_EN
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (start) begin
               opa         <= a_mag;
               opb         <= b_mag;
               acc         <= {{DW{1'b0}}, (op[0] ? a_mag : b_mag)};
               count       <= '0;
               is_div      <= op[0];
               div_by_zero <= 1'b0;
`ifdef SIGNED_OPS_EN
               neg_q       <= op[1] & (R[DW-1] ^ S[DW-1]);
               neg_r       <= op[1] & R[DW-1];
`endif
               if (!op_valid) begin
                  Y_hi <= '0;
                  Y_lo <= '0;
               end else if (div_zero) begin
                  Y_hi        <= R;
                  Y_lo        <= '1;
                  div_by_zero <= 1'b1;
               end
            end
            CALC: begin
               acc   <= step;
               count <= count + 1'b1;
               if (last_iter) begin
                  Y_hi <= res_hi;
                  Y_lo <= res_lo;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
